// File: rtl/dm_responder.sv
// Data-memory responder: little-endian word RAM plus a 16-byte MMIO page (LEDs, switches,
// free-running timer, sticky error flags). Loads are combinational, stores commit on clk.
module dm_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h00007F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_w,
  input  logic [2:0]  dm_type,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  input  logic [15:0] sw,
  output logic [31:0] Data_out,
  output logic [15:0] led,
  output logic [1:0]  err
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [31:0]   timer;
  logic          misaligned;
  logic          in_ram;
  logic          in_mmio;
  logic          mapped;
  logic          ram_we;
  logic          mmio_we;
  logic [AW-1:0] ram_idx;
  logic [4:0]    lane_shift;
  logic [31:0]   rd_word;
  logic [15:0]   rd_half;
  logic [7:0]    rd_byte;
  logic [31:0]   lane_mask;
  logic [31:0]   wr_word;

  // Undefined access sizes (101..111) fall into the misaligned bucket.
  always_comb begin
    misaligned = 1'b1;
    case (dm_type)
      3'b000:         misaligned = (Addr_in[1:0] != 2'b00);
      3'b001, 3'b010: misaligned = Addr_in[0];
      3'b011, 3'b100: misaligned = 1'b0;
      default:        misaligned = 1'b1;
    endcase
  end

  // MMIO_BASE is assumed 16-byte aligned so the page is matched on the upper address bits.
  assign in_ram     = (Addr_in < RAM_BYTES);
  assign in_mmio    = (Addr_in[31:4] == MMIO_BASE[31:4]);
  assign mapped     = in_ram || (in_mmio && (dm_type == 3'b000));
  assign ram_we     = mem_w && !misaligned && in_ram;
  assign mmio_we    = mem_w && !misaligned && mapped && !in_ram;

  assign ram_idx    = Addr_in[AW+1:2];
  assign lane_shift = {Addr_in[1:0], 3'b000};
  assign rd_word    = mem[ram_idx];
  assign rd_half    = rd_word[{Addr_in[1], 4'b0000} +: 16];
  assign rd_byte    = rd_word[lane_shift +: 8];

  // Sub-word stores merge into the old word so untouched lanes keep their value.
  always_comb begin
    lane_mask = 32'h000000FF << lane_shift;
    case (dm_type)
      3'b000:         lane_mask = 32'hFFFFFFFF;
      3'b001, 3'b010: lane_mask = 32'h0000FFFF << lane_shift;
      default:        lane_mask = 32'h000000FF << lane_shift;
    endcase
    wr_word = (rd_word & ~lane_mask) | ((Data_in << lane_shift) & lane_mask);
  end

  always_comb begin
    Data_out = 32'h0;
    if (!misaligned && mapped) begin
      if (in_ram) begin
        case (dm_type)
          3'b000:  Data_out = rd_word;
          3'b001:  Data_out = {{16{rd_half[15]}}, rd_half};
          3'b010:  Data_out = {16'h0, rd_half};
          3'b011:  Data_out = {{24{rd_byte[7]}}, rd_byte};
          3'b100:  Data_out = {24'h0, rd_byte};
          default: Data_out = 32'h0;
        endcase
      end else begin
        case (Addr_in[3:2])
          2'b00:   Data_out = {16'h0, led};
          2'b01:   Data_out = {16'h0, sw};
          2'b10:   Data_out = timer;
          default: Data_out = {30'h0, err};
        endcase
      end
    end
  end

  // RAM is never cleared; rst only suppresses a write so a store under reset is lost whole.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst && ram_we) begin
      mem[ram_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led   <= 16'h0;
      timer <= 32'h0;
      err   <= 2'b00;
    end else begin
      timer <= timer + 32'd1;
      if (mmio_we) begin
        case (Addr_in[3:2])
          2'b00:   led   <= Data_in[15:0];
          2'b10:   timer <= Data_in;
          2'b11:   err   <= err & ~Data_in[1:0];
          default: ;
        endcase
      end
      // Later assignments win, giving a new error priority over a write-1-clear.
      if (mem_w && misaligned)            err[0] <= 1'b1;
      if (mem_w && !misaligned && !mapped) err[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed scenarios plus randomized traffic checked
// against a byte-array reference model of RAM, LEDs, timer and error flags.
module tb_dm_responder;

  localparam logic [31:0] MMIO = 32'h00007F00;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_w;
  logic [2:0]  dm_type;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [15:0] sw;
  logic [31:0] Data_out;
  logic [15:0] led;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_ram [4096];
  logic [15:0] m_led;
  logic [31:0] m_timer;
  logic [1:0]  m_err;

  dm_responder #(.DEPTH(1024), .MMIO_BASE(MMIO)) dut (
    .clk(clk), .rst(rst), .mem_w(mem_w), .dm_type(dm_type), .Addr_in(Addr_in),
    .Data_in(Data_in), .sw(sw), .Data_out(Data_out), .led(led), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int acc_size(input logic [2:0] t);
    case (t)
      3'd0:       return 4;
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 0;
    endcase
  endfunction

  function automatic bit m_mis(input logic [31:0] a, input logic [2:0] t);
    int s = acc_size(t);
    return (s == 0) || ((a % s) != 0);
  endfunction

  function automatic bit m_mapped(input logic [31:0] a, input logic [2:0] t);
    return (a < 32'd4096) || (a >= MMIO && a <= MMIO + 32'd15 && acc_size(t) == 4);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] t);
    logic [31:0] v = 32'h0;
    int s = acc_size(t);
    if (m_mis(a, t) || !m_mapped(a, t)) return 32'h0;
    if (a < 32'd4096) begin
      for (int i = 0; i < s; i++) v = v + (32'(m_ram[int'(a) + i]) << (8 * i));
      if (t == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF0000;
      if (t == 3'd3 && v >= 32'h80)   v = v + 32'hFFFFFF00;
      return v;
    end
    case (a - MMIO)
      32'd0:   return 32'(m_led);
      32'd4:   return 32'(sw);
      32'd8:   return m_timer;
      default: return 32'(m_err);
    endcase
  endfunction

  task automatic model_reset();
    m_led = 16'h0; m_timer = 32'h0; m_err = 2'b00;
  endtask

  // Advance one clock edge, applying the architectural effect of the inputs held at that edge.
  task automatic tick();
    logic [31:0] nt;
    logic [1:0]  ne;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      nt = m_timer + 32'd1;
      ne = m_err;
      if (mem_w) begin
        if (m_mis(Addr_in, dm_type))          ne[0] = 1'b1;
        else if (!m_mapped(Addr_in, dm_type)) ne[1] = 1'b1;
        else if (Addr_in < 32'd4096) begin
          for (int i = 0; i < acc_size(dm_type); i++)
            m_ram[int'(Addr_in) + i] = 8'(Data_in >> (8 * i));
        end else begin
          case (Addr_in - MMIO)
            32'd0:   m_led = Data_in[15:0];
            32'd8:   nt = Data_in;
            32'd12:  ne = ne & ~Data_in[1:0];
            default: ;
          endcase
        end
      end
      m_timer = nt;
      m_err   = ne;
    end
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [2:0] t, input logic w, input logic [31:0] d);
    Addr_in = a; dm_type = t; mem_w = w; Data_in = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sw = 16'h5A5A;
    drive(MMIO + 32'd8, 3'd0, 1'b0, 32'h0);
    model_reset();
    checks++; if (led !== 16'h0) begin errors++; $display("[TB] FAIL reset_led: got %h expected 0000", led); end
    checks++; if (err !== 2'b00) begin errors++; $display("[TB] FAIL reset_err: got %b expected 00", err); end
    checks++; if (Data_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_timer: got %h expected 0", Data_out); end
    rst = 1'b0;
    #1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (Data_out !== 32'(k)) begin errors++; $display("[TB] FAIL timer_count%0d: got %h expected %h", k, Data_out, 32'(k)); end
    end
  endtask

  task automatic test_word_store();
    drive(32'h10, 3'd0, 1'b1, 32'h11223344); tick();
    drive(32'h13, 3'd3, 1'b0, 32'h0);
    checks++; if (Data_out !== 32'h00000011) begin errors++; $display("[TB] FAIL lb_0x13: got %h expected 00000011", Data_out); end
    drive(32'h12, 3'd1, 1'b0, 32'h0);
    checks++; if (Data_out !== 32'h00001122) begin errors++; $display("[TB] FAIL lh_0x12: got %h expected 00001122", Data_out); end
    drive(32'h10, 3'd0, 1'b0, 32'h0);
    checks++; if (Data_out !== 32'h11223344) begin errors++; $display("[TB] FAIL lw_0x10: got %h expected 11223344", Data_out); end
  endtask

  task automatic test_byte_store();
    drive(32'h11, 3'd3, 1'b1, 32'hFFFFFFA5); tick();
    drive(32'h11, 3'd3, 1'b0, 32'h0);
    checks++; if (Data_out !== 32'hFFFFFFA5) begin errors++; $display("[TB] FAIL lb_0x11: got %h expected FFFFFFA5", Data_out); end
    drive(32'h11, 3'd4, 1'b0, 32'h0);
    checks++; if (Data_out !== 32'h000000A5) begin errors++; $display("[TB] FAIL lbu_0x11: got %h expected 000000A5", Data_out); end
    drive(32'h10, 3'd0, 1'b0, 32'h0);
    checks++; if (Data_out !== 32'h1122A544) begin errors++; $display("[TB] FAIL lw_after_sb: got %h expected 1122A544", Data_out); end
  endtask

  task automatic test_errors();
    drive(32'h11, 3'd1, 1'b1, 32'hDEADBEEF); tick();
    drive(32'h12, 3'd0, 1'b1, 32'hCAFEBABE); tick();
    drive(32'h10, 3'd0, 1'b0, 32'h0);
    checks++; if (Data_out !== 32'h1122A544) begin errors++; $display("[TB] FAIL misaligned_ram: got %h expected 1122A544", Data_out); end
    checks++; if (err !== 2'b01) begin errors++; $display("[TB] FAIL err_misaligned: got %b expected 01", err); end
    drive(32'h00100000, 3'd0, 1'b1, 32'h12345678); tick();
    checks++; if (err !== 2'b11) begin errors++; $display("[TB] FAIL err_unmapped: got %b expected 11", err); end
    drive(32'h00100000, 3'd0, 1'b0, 32'h0);
    checks++; if (Data_out !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_load: got %h expected 0", Data_out); end
    drive(MMIO + 32'd12, 3'd0, 1'b1, 32'h1); tick();
    drive(MMIO + 32'd12, 3'd0, 1'b0, 32'h0);
    checks++; if (err !== 2'b10) begin errors++; $display("[TB] FAIL err_w1c: got %b expected 10", err); end
    checks++; if (Data_out !== 32'h2) begin errors++; $display("[TB] FAIL err_read: got %h expected 2", Data_out); end
  endtask

  task automatic test_timer_wrap();
    logic [31:0] exp_t [3] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0};
    drive(MMIO + 32'd8, 3'd0, 1'b1, 32'hFFFFFFFE); tick();
    drive(MMIO + 32'd8, 3'd0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      checks++;
      if (Data_out !== exp_t[k]) begin errors++; $display("[TB] FAIL timer_wrap%0d: got %h expected %h", k, Data_out, exp_t[k]); end
    end
  endtask

  task automatic test_led_reset();
    drive(MMIO, 3'd0, 1'b1, 32'h0000BEEF); tick();
    drive(MMIO, 3'd0, 1'b0, 32'h0);
    checks++; if (led !== 16'hBEEF) begin errors++; $display("[TB] FAIL led_store: got %h expected BEEF", led); end
    checks++; if (Data_out !== 32'h0000BEEF) begin errors++; $display("[TB] FAIL led_read: got %h expected 0000BEEF", Data_out); end
    rst = 1'b1;
    #1;
    model_reset();
    checks++; if (led !== 16'h0) begin errors++; $display("[TB] FAIL led_async_reset: got %h expected 0000", led); end
    checks++; if (err !== 2'b00) begin errors++; $display("[TB] FAIL err_async_reset: got %b expected 00", err); end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_store();
    drive(32'h20, 3'd0, 1'b1, 32'hCAFEF00D); tick();
    drive(32'h20, 3'd0, 1'b1, 32'h12345678);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(32'h20, 3'd0, 1'b0, 32'h0);
    checks++; if (Data_out !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL reset_store_lost: got %h expected CAFEF00D", Data_out); end
  endtask

  task automatic test_read_during_write();
    drive(32'h24, 3'd0, 1'b1, 32'hAAAA5555); tick();
    drive(32'h24, 3'd0, 1'b1, 32'h0BADF00D);
    checks++; if (Data_out !== 32'hAAAA5555) begin errors++; $display("[TB] FAIL rdw_old: got %h expected AAAA5555", Data_out); end
    tick();
    drive(32'h24, 3'd0, 1'b0, 32'h0);
    checks++; if (Data_out !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL rdw_new: got %h expected 0BADF00D", Data_out); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, exp;
    logic [2:0]  t;
    logic        w;
    int          r;
    for (int i = 0; i < 16; i++) begin
      drive(32'h100 + 32'(4 * i), 3'd0, 1'b1, $urandom); tick();
    end
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        a = 32'h100 + 32'($urandom_range(0, 63)); t = 3'($urandom_range(0, 7));
      end else if (r < 9) begin
        a = MMIO + 32'(4 * $urandom_range(0, 3)); t = 3'($urandom_range(0, 4));
      end else begin
        a = 32'h00100000 + 32'(4 * $urandom_range(0, 255)); t = 3'($urandom_range(0, 4));
      end
      w = ($urandom_range(0, 9) < 4);
      d = $urandom;
      sw = 16'($urandom);
      drive(a, t, w, d);
      exp = m_load(a, t);
      checks++;
      if (Data_out !== exp) begin errors++; $display("[TB] FAIL rand_load%0d: addr %h type %0d got %h expected %h", i, a, t, Data_out, exp); end
      checks++;
      if (err !== m_err) begin errors++; $display("[TB] FAIL rand_err%0d: got %b expected %b", i, err, m_err); end
      checks++;
      if (led !== m_led) begin errors++; $display("[TB] FAIL rand_led%0d: got %h expected %h", i, led, m_led); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; mem_w = 1'b0; dm_type = 3'd0; Addr_in = 32'h0; Data_in = 32'h0; sw = 16'h0;
    test_reset();
    test_word_store();
    test_byte_store();
    test_errors();
    test_timer_wrap();
    test_led_reset();
    test_reset_mid_store();
    test_read_during_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
